// File: rtl/branch_predictor_btb_pkg.sv
// Shared definitions for the branch target buffer: PC field layout, update
// actions and the weak-taken counter seed.
package branch_predictor_btb_pkg;

  localparam int PC_W      = 32;
  localparam int PC_ALIGN  = 2;
  localparam int CNT_MAX_W = 4;

  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_TRAIN,
    UPD_ALLOC,
    UPD_INV
  } upd_act_e;

  // Weakly-taken seed for a freshly allocated entry: MSB set, rest clear.
  function automatic logic [CNT_MAX_W-1:0] weak_taken(input int w);
    return CNT_MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down counter used on the BTB update path to retrain the
// direction counter of the entry being written.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] in,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] out
);

  always_comb begin
    out = in;
    if (inc && !dec) begin
      if (in != '1) out = in + W'(1);
    end else if (dec && !inc) begin
      if (in != '0) out = in - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with per-entry saturating direction
// counters, zero-latency lookup for IF and training from ID.
module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   lu_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_pred_taken,
  input  logic [PC_W-1:0]   upd_pred_tgt,
  input  logic              inv,
  output logic              mispredict,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + PC_ALIGN;
  localparam int TAG_HI = TAG_LO + TAG_W - 1;

  localparam logic [CNT_MAX_W-1:0] WEAK_FULL = weak_taken(CNT_W);
  localparam logic [CNT_W-1:0]     WEAK      = WEAK_FULL[CNT_W-1:0];

  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v,
                                                 input logic en);
    return (en && (v != '1)) ? v + STAT_W'(1) : v;
  endfunction

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [PC_W-1:0]   target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [IDX_W-1:0]  lu_idx, upd_idx;
  logic [TAG_W-1:0]  lu_tag, upd_tag;
  logic              lu_hit, upd_hit;
  logic [CNT_W-1:0]  cnt_next;
  upd_act_e          upd_act;

  assign lu_idx  = lu_pc[TAG_LO-1:PC_ALIGN];
  assign lu_tag  = lu_pc[TAG_HI:TAG_LO];
  assign upd_idx = upd_pc[TAG_LO-1:PC_ALIGN];
  assign upd_tag = upd_pc[TAG_HI:TAG_LO];

  // Fetch-side lookup reads the registered table, so a same-cycle write is
  // only visible from the following cycle.
  assign lu_hit      = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
  assign pred_taken  = lu_hit && cnt_q[lu_idx][CNT_W-1];
  assign pred_target = pred_taken ? target_q[lu_idx] : '0;

  assign upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_tgt)));

  sat_counter #(.W(CNT_W)) u_dir_cnt (
    .in  (cnt_q[upd_idx]),
    .inc (upd_taken),
    .dec (!upd_taken),
    .out (cnt_next)
  );

  always_comb begin
    upd_act = UPD_NONE;
    if (inv) begin
      upd_act = UPD_INV;
    end else if (upd_valid) begin
      if (upd_hit)        upd_act = UPD_TRAIN;
      else if (upd_taken) upd_act = UPD_ALLOC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      case (upd_act)
        UPD_INV: begin
          for (int i = 0; i < ENTRIES; i++) valid_q[i] <= 1'b0;
        end
        UPD_TRAIN: begin
          cnt_q[upd_idx] <= cnt_next;
          if (upd_taken) target_q[upd_idx] <= upd_target;
        end
        UPD_ALLOC: begin
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= upd_target;
          cnt_q[upd_idx]    <= WEAK;
        end
        default: ;
      endcase
    end
  end

  // Statistics keep counting even when an invalidate pre-empts the table write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      stat_branches <= stat_inc(stat_branches, upd_valid);
      stat_mispred  <= stat_inc(stat_mispred, mispredict);
    end
  end

  generate
    if (TAG_HI < PC_W - 1) begin : g_unused_hi
      logic unused_hi;
      assign unused_hi = ^{lu_pc[PC_W-1:TAG_HI+1], upd_pc[PC_W-1:TAG_HI+1]};
    end
  endgenerate

  logic unused_lo;
  assign unused_lo = ^{lu_pc[PC_ALIGN-1:0], upd_pc[PC_ALIGN-1:0]};

endmodule
